// File: rtl/prefetcher_pkg.sv
// Shared types and defaults for the prefetcher blocks: issuer FSM states and
// the address/outstanding widths the controller and issuer agree on.
package prefetcher_pkg;

  localparam int ADDR_BITS_DFLT         = 64;
  localparam int LOG_OUTSTAND_REQS_DFLT = 6;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_STALL = 2'd2
  } issuer_state_t;

endpackage

// File: rtl/outstanding_cnt.sv
// Up/down counter of in-flight reads: saturates at 0 and MAX_CNT, with a
// registered almost-full flag. Exposes its next value so callers can look ahead.
module outstanding_cnt #(
  parameter int CNT_W         = 7,
  parameter int MAX_CNT       = 64,
  parameter int ALMOST_MARGIN = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [CNT_W-1:0] cnt_next_o,
  output logic             almost_o
);

  localparam logic [CNT_W-1:0] MAXV = CNT_W'(MAX_CNT);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] THR  =
    (MAX_CNT > ALMOST_MARGIN) ? CNT_W'(MAX_CNT - ALMOST_MARGIN) : '0;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             almost_q;

  always_comb begin
    cnt_d = cnt_q;
    // Simultaneous increment and decrement cancel out.
    if (inc_i && !dec_i && cnt_q != MAXV) begin
      cnt_d = cnt_q + ONE;
    end else if (dec_i && !inc_i && cnt_q != '0) begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      almost_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      almost_q <= (cnt_d >= THR);
    end
  end

  assign cnt_o      = cnt_q;
  assign cnt_next_o = cnt_d;
  assign almost_o   = almost_q;

endmodule

// File: rtl/prefetch_req_issuer.sv
// Walks PREFETCH_DEPTH strides from each in-window trigger, issuing one read
// per handshake; stops at the window edge, on address wrap, or when reads are full.
module prefetch_req_issuer
  import prefetcher_pkg::*;
#(
  parameter int ADDR_BITS         = ADDR_BITS_DFLT,
  parameter int LOG_OUTSTAND_REQS = LOG_OUTSTAND_REQS_DFLT,
  parameter int PREFETCH_DEPTH    = 4,
  parameter int ALMOST_MARGIN     = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic                         prefetchedAddrValid,
  input  logic [ADDR_BITS-1:0]         prefetchedAddr,
  input  logic [ADDR_BITS-1:0]         stride,
  input  logic                         flushN,
  input  logic [ADDR_BITS-1:0]         bar,
  input  logic [ADDR_BITS-1:0]         limit,
  input  logic                         memReqReady,
  input  logic                         memRespValid,
  output logic                         memReqValid,
  output logic [ADDR_BITS-1:0]         memReqAddr,
  output logic [LOG_OUTSTAND_REQS:0]   outstandingCnt,
  output logic                         almostMaxOutstanding,
  output logic                         busy
);

  localparam int                         CNT_W   = LOG_OUTSTAND_REQS + 1;
  localparam int                         MAX_CNT = 1 << LOG_OUTSTAND_REQS;
  localparam logic [CNT_W-1:0]           MAXV    = CNT_W'(MAX_CNT);
  localparam logic [7:0]                 DEPTH   = 8'(PREFETCH_DEPTH);

  issuer_state_t          state_q, state_d;
  logic                   valid_q, valid_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [ADDR_BITS-1:0]   stride_q, stride_d;
  logic [7:0]             remaining_q, remaining_d;

  logic [ADDR_BITS:0]     sum;
  logic [ADDR_BITS-1:0]   new_addr;
  logic [7:0]             rem_left;
  logic                   wrap, new_in_win, burst_done;
  logic                   hs, trig;
  logic [CNT_W-1:0]       cnt_next;
  logic                   full_next;
  logic                   go_issue;

  // Extra bit of the adder is the carry; for a negative stride a missing carry is a borrow.
  assign sum        = {1'b0, addr_q} + {1'b0, stride_q};
  assign new_addr   = sum[ADDR_BITS-1:0];
  assign wrap       = stride_q[ADDR_BITS-1] ? ~sum[ADDR_BITS] : sum[ADDR_BITS];
  assign new_in_win = (new_addr >= bar) && (new_addr <= limit);
  assign rem_left   = remaining_q - 8'd1;
  assign burst_done = (rem_left == 8'd0) || (stride_q == '0) || wrap || !new_in_win;

  // en gates the visible valid so memory never sees a request while frozen.
  assign hs   = valid_q && en && memReqReady;
  assign trig = prefetchedAddrValid && flushN && en &&
                (prefetchedAddr >= bar) && (prefetchedAddr <= limit);

  assign full_next = (cnt_next == MAXV);

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    addr_d      = addr_q;
    stride_d    = stride_q;
    remaining_d = remaining_q;
    go_issue    = 1'b0;
    if (!flushN) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
    end else if (en) begin
      if (hs) begin
        addr_d      = new_addr;
        remaining_d = rem_left;
      end
      case (state_q)
        S_ISSUE: begin
          if (hs && burst_done) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
          end else begin
            go_issue = 1'b1;
          end
        end
        S_STALL: go_issue = memRespValid;
        default: go_issue = 1'b0;
      endcase
      if (trig) begin
        addr_d      = prefetchedAddr;
        stride_d    = stride;
        remaining_d = DEPTH;
        go_issue    = 1'b1;
      end
      // Any move toward issuing parks in S_STALL if the count will be full.
      if (go_issue) begin
        state_d = full_next ? S_STALL : S_ISSUE;
        valid_d = !full_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      valid_q     <= 1'b0;
      addr_q      <= '0;
      stride_q    <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      addr_q      <= addr_d;
      stride_q    <= stride_d;
      remaining_q <= remaining_d;
    end
  end

  outstanding_cnt #(
    .CNT_W         (CNT_W),
    .MAX_CNT       (MAX_CNT),
    .ALMOST_MARGIN (ALMOST_MARGIN)
  ) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .inc_i      (hs),
    .dec_i      (memRespValid),
    .cnt_o      (outstandingCnt),
    .cnt_next_o (cnt_next),
    .almost_o   (almostMaxOutstanding)
  );

  assign memReqValid = valid_q && en;
  assign memReqAddr  = addr_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_prefetch_req_issuer.sv
// Bench for prefetch_req_issuer: two instances (default sizing, and a 4-deep
// outstanding / 8-deep walk variant) driven in parallel against a behavioural model.
module tb_prefetch_req_issuer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, pav, flushN, ready, resp;
  logic [63:0] paddr, strd, bar, limit;

  logic        vA, almA, bA;
  logic [63:0] aA;
  logic [6:0]  cA;
  logic        vB, almB, bB;
  logic [63:0] aB;
  logic [2:0]  cB;

  int vectors = 0;
  int errs    = 0;

  prefetch_req_issuer #(.ADDR_BITS(64), .LOG_OUTSTAND_REQS(6), .PREFETCH_DEPTH(4),
                        .ALMOST_MARGIN(2)) dut_a (
    .clk(clk), .reset(rst), .en(en), .prefetchedAddrValid(pav), .prefetchedAddr(paddr),
    .stride(strd), .flushN(flushN), .bar(bar), .limit(limit), .memReqReady(ready),
    .memRespValid(resp), .memReqValid(vA), .memReqAddr(aA), .outstandingCnt(cA),
    .almostMaxOutstanding(almA), .busy(bA));

  prefetch_req_issuer #(.ADDR_BITS(64), .LOG_OUTSTAND_REQS(2), .PREFETCH_DEPTH(8),
                        .ALMOST_MARGIN(2)) dut_b (
    .clk(clk), .reset(rst), .en(en), .prefetchedAddrValid(pav), .prefetchedAddr(paddr),
    .stride(strd), .flushN(flushN), .bar(bar), .limit(limit), .memReqReady(ready),
    .memRespValid(resp), .memReqValid(vB), .memReqAddr(aB), .outstandingCnt(cB),
    .almostMaxOutstanding(almB), .busy(bB));

  // Reference model: index 0 tracks dut_a, index 1 tracks dut_b.
  int          MAXC [2] = '{64, 4};
  int          DEPTH[2] = '{4, 8};
  logic        m_vld[2], m_busy[2], m_stall[2], m_alm[2];
  logic [63:0] m_addr[2], m_str[2];
  int          m_left[2], m_cnt[2];

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      logic hs, want, done, wrap;
      logic [63:0] na;
      int nc;
      hs = m_vld[k] && en && ready;
      nc = m_cnt[k];
      if (hs && !resp) nc = nc + 1;
      else if (resp && !hs && nc > 0) nc = nc - 1;
      if (rst) begin
        m_vld[k] = 0; m_busy[k] = 0; m_stall[k] = 0; m_alm[k] = 0;
        m_addr[k] = 0; m_str[k] = 0; m_left[k] = 0; m_cnt[k] = 0;
      end else begin
        m_cnt[k] = nc;
        m_alm[k] = (nc >= MAXC[k] - 2);
        if (!flushN) begin
          m_vld[k] = 0; m_busy[k] = 0; m_stall[k] = 0;
        end else if (en) begin
          want = 0;
          if (hs) begin
            na   = m_addr[k] + m_str[k];
            wrap = m_str[k][63] ? (m_addr[k] < (64'd0 - m_str[k]))
                                : (m_addr[k] > (~64'd0 - m_str[k]));
            done = (m_left[k] == 1) || (m_str[k] == 0) || wrap || (na < bar) || (na > limit);
            m_addr[k] = na;
            m_left[k] = m_left[k] - 1;
            if (done) begin m_vld[k] = 0; m_busy[k] = 0; end
            else want = 1;
          end
          if (m_stall[k] && resp) want = 1;
          if (pav && paddr >= bar && paddr <= limit) begin
            m_addr[k] = paddr; m_str[k] = strd; m_left[k] = DEPTH[k]; want = 1;
          end
          if (want) begin
            m_busy[k]  = 1;
            m_stall[k] = (nc == MAXC[k]);
            m_vld[k]   = !m_stall[k];
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1; en = 1; pav = 0; paddr = 0; strd = 0; flushN = 1;
    bar = 64'h1000; limit = 64'h1FFF; ready = 0; resp = 0;
    tick();
    rst = 0;
  endtask

  task automatic trigger(input logic [63:0] a, input logic [63:0] s);
    pav = 1; paddr = a; strd = s;
    tick();
    pav = 0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({vA, aA, cA, almA, bA} !== '0 || {vB, aB, cB, almB, bB} !== '0) begin
      errs++;
      $display("FAIL reset: A v=%0b a=%h c=%0d al=%0b b=%0b  B v=%0b a=%h c=%0d al=%0b b=%0b, want all 0",
               vA, aA, cA, almA, bA, vB, aB, cB, almB, bB);
    end
  endtask

  task automatic test_basic_walk();
    do_reset();
    ready = 1;
    trigger(64'h1000, 64'h40);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (vA !== 1'b1 || aA !== 64'h1000 + 64'(i) * 64'h40) begin
        errs++;
        $display("FAIL walk[%0d]: valid=%0b addr=%h, want 1 %h", i, vA, aA, 64'h1000 + 64'(i) * 64'h40);
      end
      tick();
    end
    vectors++;
    if (vA !== 1'b0 || bA !== 1'b0 || cA !== 7'd4 || almA !== 1'b0) begin
      errs++;
      $display("FAIL walk_end: valid=%0b busy=%0b cnt=%0d almost=%0b, want 0 0 4 0", vA, bA, cA, almA);
    end
    vectors++;
    if (vB !== 1'b0 || bB !== 1'b1 || cB !== 3'd4 || almB !== 1'b1) begin
      errs++;
      $display("FAIL walk_small_stall: valid=%0b busy=%0b cnt=%0d almost=%0b, want 0 1 4 1", vB, bB, cB, almB);
    end
  endtask

  task automatic test_window_stop();
    do_reset();
    ready = 1;
    trigger(64'h1FC0, 64'h40);
    vectors++;
    if (vA !== 1'b1 || aA !== 64'h1FC0) begin
      errs++; $display("FAIL win_hi_first: valid=%0b addr=%h, want 1 1fc0", vA, aA);
    end
    tick();
    vectors++;
    if (vA !== 1'b0 || bA !== 1'b0 || cA !== 7'd1) begin
      errs++; $display("FAIL win_hi_stop: valid=%0b busy=%0b cnt=%0d, want 0 0 1", vA, bA, cA);
    end
    trigger(64'h1000, -64'sd64);
    vectors++;
    if (vA !== 1'b1 || aA !== 64'h1000) begin
      errs++; $display("FAIL win_neg_first: valid=%0b addr=%h, want 1 1000", vA, aA);
    end
    tick();
    vectors++;
    if (vA !== 1'b0 || bA !== 1'b0 || cA !== 7'd2) begin
      errs++; $display("FAIL win_neg_stop: valid=%0b busy=%0b cnt=%0d, want 0 0 2", vA, bA, cA);
    end
    trigger(64'h2400, 64'h40);
    vectors++;
    if (vA !== 1'b0 || bA !== 1'b0) begin
      errs++; $display("FAIL win_outside: valid=%0b busy=%0b, want 0 0", vA, bA);
    end
  endtask

  task automatic test_outstanding_limit();
    do_reset();
    ready = 1;
    trigger(64'h1000, 64'h10);
    repeat (6) tick();
    vectors++;
    if (vB !== 1'b0 || bB !== 1'b1 || cB !== 3'd4) begin
      errs++; $display("FAIL stall: valid=%0b busy=%0b cnt=%0d, want 0 1 4", vB, bB, cB);
    end
    resp = 1;
    tick();
    resp = 0;
    vectors++;
    if (vB !== 1'b1 || aB !== 64'h1040 || cB !== 3'd3) begin
      errs++; $display("FAIL stall_release: valid=%0b addr=%h cnt=%0d, want 1 1040 3", vB, aB, cB);
    end
    tick();
    tick();
    vectors++;
    if (vB !== 1'b0 || bB !== 1'b1 || cB !== 3'd4) begin
      errs++; $display("FAIL stall_one_more: valid=%0b busy=%0b cnt=%0d, want 0 1 4", vB, bB, cB);
    end
  endtask

  task automatic test_flush();
    do_reset();
    ready = 1;
    trigger(64'h1000, 64'h40);
    tick();
    tick();
    ready = 0;
    tick();
    tick();
    vectors++;
    if (vA !== 1'b1 || aA !== 64'h1080 || cA !== 7'd2) begin
      errs++; $display("FAIL hold_stable: valid=%0b addr=%h cnt=%0d, want 1 1080 2", vA, aA, cA);
    end
    flushN = 0;
    pav = 1; paddr = 64'h1400; strd = 64'h40;
    tick();
    flushN = 1; pav = 0;
    vectors++;
    if (vA !== 1'b0 || bA !== 1'b0 || cA !== 7'd2) begin
      errs++; $display("FAIL flush: valid=%0b busy=%0b cnt=%0d, want 0 0 2", vA, bA, cA);
    end
    resp = 1;
    tick();
    tick();
    tick();
    resp = 0;
    vectors++;
    if (cA !== 7'd0 || cB !== 3'd0) begin
      errs++; $display("FAIL drain_sat: cntA=%0d cntB=%0d, want 0 0", cA, cB);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    ready = 1;
    trigger(64'h1000, 64'h40);
    tick();
    resp = 1;
    tick();
    resp = 0;
    vectors++;
    if (cA !== 7'd1 || aA !== 64'h1080) begin
      errs++; $display("FAIL hs_resp: cnt=%0d addr=%h, want 1 1080", cA, aA);
    end
    trigger(64'h1800, 64'h40);
    vectors++;
    if (vA !== 1'b1 || aA !== 64'h1800 || cA !== 7'd2) begin
      errs++; $display("FAIL retrigger: valid=%0b addr=%h cnt=%0d, want 1 1800 2", vA, aA, cA);
    end
    tick();
    vectors++;
    if (aA !== 64'h1840 || cA !== 7'd3) begin
      errs++; $display("FAIL retrigger_walk: addr=%h cnt=%0d, want 1840 3", aA, cA);
    end
  endtask

  task automatic test_reset_enable();
    do_reset();
    ready = 1;
    trigger(64'h1000, 64'h40);
    tick();
    en = 0;
    #1;
    vectors++;
    if (vA !== 1'b0) begin
      errs++; $display("FAIL en_low_valid: valid=%0b, want 0", vA);
    end
    resp = 1;
    tick();
    resp = 0;
    tick();
    tick();
    vectors++;
    if (vA !== 1'b0 || bA !== 1'b1 || cA !== 7'd0) begin
      errs++; $display("FAIL en_frozen: valid=%0b busy=%0b cnt=%0d, want 0 1 0", vA, bA, cA);
    end
    en = 1;
    #1;
    vectors++;
    if (vA !== 1'b1 || aA !== 64'h1040) begin
      errs++; $display("FAIL en_resume: valid=%0b addr=%h, want 1 1040", vA, aA);
    end
    tick();
    rst = 1;
    tick();
    rst = 0;
    vectors++;
    if ({vA, aA, cA, almA, bA} !== '0 || {vB, aB, cB, almB, bB} !== '0) begin
      errs++; $display("FAIL reset_mid: A v=%0b a=%h c=%0d b=%0b  B v=%0b a=%h c=%0d b=%0b, want all 0",
                       vA, aA, cA, bA, vB, aB, cB, bB);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 300 == 0) begin
        case ($urandom_range(0, 2))
          0: begin bar = 64'h1000; limit = 64'h1FFF; end
          1: begin bar = 64'h0;    limit = ~64'h0;   end
          default: begin bar = 64'h2000; limit = 64'h20FF; end
        endcase
      end
      rst    = ($urandom_range(0, 199) == 0);
      en     = ($urandom_range(0, 9) != 0);
      flushN = ($urandom_range(0, 39) != 0);
      ready  = ($urandom_range(0, 3) != 0);
      resp   = ($urandom_range(0, 2) == 0);
      pav    = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0: paddr = bar + 64'($urandom_range(0, 255)) * 64'h10;
        1: paddr = {32'($urandom), 32'($urandom)};
        2: paddr = 64'hFFFF_FFFF_FFFF_FF00 + 64'($urandom_range(0, 255));
        default: paddr = 64'($urandom_range(0, 255));
      endcase
      case ($urandom_range(0, 4))
        0: strd = 64'h40;
        1: strd = -64'sd64;
        2: strd = 64'h0;
        3: strd = 64'(signed'(32'($urandom_range(0, 511)) - 32'sd256));
        default: strd = 64'h100;
      endcase
      tick();
      vectors++;
      if (vA !== (m_vld[0] & en) || cA !== 7'(m_cnt[0]) || almA !== m_alm[0] || bA !== m_busy[0] ||
          (m_vld[0] && aA !== m_addr[0])) begin
        errs++;
        $display("FAIL rand_a[%0d]: v=%0b a=%h c=%0d al=%0b b=%0b, want v=%0b a=%h c=%0d al=%0b b=%0b",
                 cyc, vA, aA, cA, almA, bA, m_vld[0] & en, m_addr[0], m_cnt[0], m_alm[0], m_busy[0]);
      end
      vectors++;
      if (vB !== (m_vld[1] & en) || cB !== 3'(m_cnt[1]) || almB !== m_alm[1] || bB !== m_busy[1] ||
          (m_vld[1] && aB !== m_addr[1])) begin
        errs++;
        $display("FAIL rand_b[%0d]: v=%0b a=%h c=%0d al=%0b b=%0b, want v=%0b a=%h c=%0d al=%0b b=%0b",
                 cyc, vB, aB, cB, almB, bB, m_vld[1] & en, m_addr[1], m_cnt[1], m_alm[1], m_busy[1]);
      end
    end
    rst = 0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_vld[k] = 0; m_busy[k] = 0; m_stall[k] = 0; m_alm[k] = 0;
      m_addr[k] = 0; m_str[k] = 0; m_left[k] = 0; m_cnt[k] = 0;
    end
    rst = 1; en = 1; pav = 0; paddr = 0; strd = 0; flushN = 1;
    bar = 64'h1000; limit = 64'h1FFF; ready = 0; resp = 0;
    test_reset();
    test_basic_walk();
    test_window_stop();
    test_outstanding_limit();
    test_flush();
    test_simultaneous();
    test_reset_enable();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
